// File: rtl/tile_map_writer.sv
// Write port of the level tile map: bulk-loads a level's rows from ROM and
// serves single-tile clear requests from collision logic.
module tile_map_writer #(
  parameter int unsigned ROWS   = 15,
  parameter int unsigned COLS   = 20,
  parameter int unsigned LEVELS = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            level_start,
  input  logic [3:0]      level,
  output logic [3:0]      rom_level,
  output logic [3:0]      rom_row,
  input  logic [COLS-1:0] rom_data,
  input  logic            clr_req,
  input  logic [10:0]     clr_x,
  input  logic [10:0]     clr_y,
  output logic            clr_ack,
  output logic            wr_en,
  output logic [3:0]      wr_row,
  output logic [COLS-1:0] wr_mask,
  output logic [COLS-1:0] wr_data,
  output logic            busy,
  output logic            load_done
);

  localparam int unsigned ROW_W      = 4;
  localparam int unsigned LVL_W      = 4;
  localparam int unsigned TILE_SHIFT = 5;
  localparam int unsigned TILE_W     = 11 - TILE_SHIFT;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, CLR} state_t;

  state_t             state, state_n;
  logic [LVL_W-1:0]   rom_level_n;
  logic [ROW_W-1:0]   rom_row_n, wr_row_n;
  logic [COLS-1:0]    wr_mask_n;
  logic               wr_en_n, clr_ack_n, load_done_n, busy_n;
  logic               lvl_bad, lvl_bad_n;
  logic [TILE_W-1:0]  clr_row, clr_col;
  logic               clr_in_range;

  // Pixel to tile coordinates of the pending clear request
  assign clr_row      = TILE_W'(clr_y >> TILE_SHIFT);
  assign clr_col      = TILE_W'(clr_x >> TILE_SHIFT);
  assign clr_in_range = (clr_row < TILE_W'(ROWS)) && (clr_col < TILE_W'(COLS));

  // Only load data reaches the RAM; an out-of-range level loads an empty map
  assign wr_data = ((state == LOAD || state == DRAIN) && !lvl_bad) ? rom_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rom_level <= '0;
      rom_row   <= '0;
      wr_en     <= 1'b0;
      wr_row    <= '0;
      wr_mask   <= '0;
      clr_ack   <= 1'b0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      lvl_bad   <= 1'b0;
    end else begin
      state     <= state_n;
      rom_level <= rom_level_n;
      rom_row   <= rom_row_n;
      wr_en     <= wr_en_n;
      wr_row    <= wr_row_n;
      wr_mask   <= wr_mask_n;
      clr_ack   <= clr_ack_n;
      load_done <= load_done_n;
      busy      <= busy_n;
      lvl_bad   <= lvl_bad_n;
    end
  end

  always_comb begin
    state_n     = state;
    rom_level_n = rom_level;
    rom_row_n   = rom_row;
    wr_en_n     = 1'b0;
    wr_row_n    = wr_row;
    wr_mask_n   = wr_mask;
    clr_ack_n   = 1'b0;
    load_done_n = 1'b0;
    lvl_bad_n   = lvl_bad;
    case (state)
      IDLE: begin
        if (level_start) begin
          state_n     = LOAD;
          rom_level_n = level;
          rom_row_n   = '0;
          lvl_bad_n   = (level >= LVL_W'(LEVELS));
        end else if (clr_req) begin
          state_n   = CLR;
          wr_en_n   = clr_in_range;
          wr_row_n  = ROW_W'(clr_row);
          wr_mask_n = clr_in_range ? (COLS'(1) << clr_col) : '0;
          clr_ack_n = 1'b1;
        end
      end
      // ROM is registered, so the row addressed now is written next cycle
      LOAD: begin
        wr_en_n   = 1'b1;
        wr_row_n  = rom_row;
        wr_mask_n = '1;
        if (rom_row == ROW_W'(ROWS - 1)) begin
          state_n = DRAIN;
        end else begin
          rom_row_n = rom_row + ROW_W'(1);
        end
      end
      DRAIN: begin
        state_n     = DONE;
        load_done_n = 1'b1;
      end
      DONE:    state_n = IDLE;
      CLR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_tile_map_writer.sv
// Randomized bench for tile_map_writer: registered ROM and RAM models plus an
// expected tile map derived from level contents and clear coordinates.
module tb_tile_map_writer;

  localparam int ROWS   = 15;
  localparam int COLS   = 20;
  localparam int LEVELS = 7;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            level_start = 1'b0;
  logic [3:0]      level = '0;
  logic [3:0]      rom_level;
  logic [3:0]      rom_row;
  logic [COLS-1:0] rom_data = '0;
  logic            clr_req = 1'b0;
  logic [10:0]     clr_x = '0;
  logic [10:0]     clr_y = '0;
  logic            clr_ack, wr_en, busy, load_done;
  logic [3:0]      wr_row;
  logic [COLS-1:0] wr_mask, wr_data;

  logic [COLS-1:0] rom_tab [16][ROWS];
  logic [COLS-1:0] ram     [ROWS];
  logic [COLS-1:0] exp_map [ROWS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_map_writer #(.ROWS(ROWS), .COLS(COLS), .LEVELS(LEVELS)) dut (
    .clk(clk), .reset(reset), .level_start(level_start), .level(level),
    .rom_level(rom_level), .rom_row(rom_row), .rom_data(rom_data),
    .clr_req(clr_req), .clr_x(clr_x), .clr_y(clr_y), .clr_ack(clr_ack),
    .wr_en(wr_en), .wr_row(wr_row), .wr_mask(wr_mask), .wr_data(wr_data),
    .busy(busy), .load_done(load_done)
  );

  // Registered level ROM
  always @(posedge clk)
    rom_data <= (rom_row < 4'(ROWS)) ? rom_tab[rom_level][rom_row] : '0;

  // Tile-map RAM with per-column write enables
  always @(posedge clk)
    if (wr_en && wr_row < 4'(ROWS))
      ram[wr_row] <= (ram[wr_row] & ~wr_mask) | (wr_data & wr_mask);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [COLS-1:0] level_row(input int lvl, input int r);
    return (lvl < LEVELS) ? rom_tab[lvl][r] : '0;
  endfunction

  task automatic check_map();
    for (int r = 0; r < ROWS; r++) check($sformatf("map_row%0d", r), 32'(ram[r]), 32'(exp_map[r]));
  endtask

  task automatic load_level(input int lvl, input bit with_clr);
    int cx, cy;
    cx = $urandom_range(0, 639);
    cy = $urandom_range(0, 479);
    @(posedge clk); #1;
    level_start = 1'b1;
    level       = 4'(lvl);
    if (with_clr) begin
      clr_req = 1'b1; clr_x = 11'(cx); clr_y = 11'(cy);
    end
    @(negedge clk);
    check("load_c0_busy", 32'(busy), 0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      level_start = (c == 5);
      level       = 4'($urandom);
      if (c == 20) clr_req = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check("load_rom_level", 32'(rom_level), 32'(lvl));
        check("load_rom_row0", 32'(rom_row), 0);
      end
      if (c >= 2 && c <= 16) begin
        check("load_wr_en", 32'(wr_en), 1);
        check("load_wr_row", 32'(wr_row), 32'(c - 2));
        check("load_wr_mask", 32'(wr_mask), 32'((1 << COLS) - 1));
        check("load_wr_data", 32'(wr_data), 32'(level_row(lvl, c - 2)));
      end else if (with_clr && c == 19) begin
        check("tie_clr_wr_en", 32'(wr_en), 1);
        check("tie_clr_row", 32'(wr_row), 32'(cy / 32));
        check("tie_clr_mask", 32'(wr_mask), 32'(1 << (cx / 32)));
        check("tie_clr_data", 32'(wr_data), 0);
      end else begin
        check("load_no_wr", 32'(wr_en), 0);
      end
      check("load_done", 32'(load_done), 32'(c == 17));
      check("load_busy", 32'(busy), 32'(c <= 17 || (with_clr && c == 19)));
      check("load_clr_ack", 32'(clr_ack), 32'(with_clr && c == 19));
    end
    for (int r = 0; r < ROWS; r++) exp_map[r] = level_row(lvl, r);
    if (with_clr) exp_map[cy / 32][cx / 32] = 1'b0;
  endtask

  task automatic do_clear(input int x, input int y, input bit hold);
    bit inr;
    inr = (y / 32 < ROWS) && (x / 32 < COLS);
    @(posedge clk); #1;
    clr_req = 1'b1; clr_x = 11'(x); clr_y = 11'(y);
    @(negedge clk);
    check("clr_idle_ack", 32'(clr_ack), 0);
    check("clr_idle_wr", 32'(wr_en), 0);
    for (int k = 0; k < (hold ? 2 : 1); k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("clr_ack", 32'(clr_ack), 1);
      check("clr_busy", 32'(busy), 1);
      check("clr_wr_en", 32'(wr_en), 32'(inr));
      if (inr) begin
        check("clr_wr_row", 32'(wr_row), 32'(y / 32));
        check("clr_wr_mask", 32'(wr_mask), 32'(1 << (x / 32)));
        check("clr_wr_data", 32'(wr_data), 0);
      end
      @(posedge clk); #1;
      if (!hold || k == 1) clr_req = 1'b0;
      @(negedge clk);
      check("clr_after_ack", 32'(clr_ack), 0);
      check("clr_after_wr", 32'(wr_en), 0);
      check("clr_after_busy", 32'(busy), 0);
    end
    if (inr) exp_map[y / 32][x / 32] = 1'b0;
  endtask

  task automatic reset_mid_load();
    @(posedge clk); #1;
    level_start = 1'b1; level = 4'd1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      level_start = 1'b0;
      if (c == 7) reset = 1'b1;
      @(negedge clk);
      if (c == 8) begin
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_mask", 32'(wr_mask), 0);
        check("rst_rom_row", 32'(rom_row), 0);
        check("rst_wr_row", 32'(wr_row), 0);
        check("rst_load_done", 32'(load_done), 0);
      end else if (c >= 2) begin
        check("rst_pre_wr_en", 32'(wr_en), 1);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (wr_en || busy || load_done) check("rst_quiet", {wr_en, busy, load_done}, 0);
    end
    check("rst_stays_idle", 32'(busy), 0);
    for (int r = 0; r < 6; r++) exp_map[r] = rom_tab[1][r];
  endtask

  initial begin
    for (int l = 0; l < 16; l++)
      for (int r = 0; r < ROWS; r++) rom_tab[l][r] = COLS'($urandom | 1);
    for (int r = 0; r < ROWS; r++) begin
      ram[r] = '0; exp_map[r] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_clr_ack", 32'(clr_ack), 0);
    check("reset_load_done", 32'(load_done), 0);
    check("reset_rom_addr", {rom_level, rom_row}, 0);
    check("reset_wr_row_mask", {wr_row, wr_mask}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    load_level(0, 1'b0);
    check_map();
    do_clear(70, 200, 1'b0);
    check_map();
    do_clear(700, 100, 1'b0);
    check_map();
    load_level(3, 1'b1);
    check_map();
    reset_mid_load();
    check_map();
    load_level(9, 1'b0);
    check_map();
    check("invalid_busy_after", 32'(busy), 0);
    load_level(5, 1'b0);
    do_clear($urandom_range(0, 639), $urandom_range(0, 479), 1'b1);
    check_map();

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0)
        load_level($urandom_range(0, 10), 1'($urandom));
      else
        do_clear($urandom_range(0, 799), $urandom_range(0, 599), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_no_wr", 32'(wr_en), 0);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check_map();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
